tdc_event_sequencer: RTL and testbench
======================================

TDC_EVENT_SEQUENCER -- requirements
Module: tdc_event_sequencer

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 255, meaning max cycles a request waits for its done before abort (range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port hit_valid, input, 1, one-cycle strobe: hit_data is valid.
REQ-005 SHALL have port hit_data, input, 48, TDC measurement word.
REQ-006 SHALL have ports line_sync_in and frame_sync_in, input, 1 each, asynchronous level sync signals from the scanner.
REQ-007 SHALL have port fifo_full, input, 1, downstream FIFO full flag.
REQ-008 SHALL have ports s1_fifo_writing_done, new_line_FIFO_done, new_frame_FIFO_done, input, 1 each, acknowledges from the FIFO manager.
REQ-009 SHALL have port s1_wr_en, output, 1, hit write request.
REQ-010 SHALL have port s1_din, output, 48, hit word to write.
REQ-011 SHALL have ports new_line and new_frame, output, 1 each, marker write requests.
REQ-012 SHALL have port line_index, output, 16, number of lines accepted since the last frame marker.
REQ-013 SHALL have port drop_cnt, output, 16, saturating count of discarded events.
REQ-014 SHALL have port ack_timeout_err, output, 1, sticky error flag.

Function
REQ-015 SHALL synchronize line_sync_in and frame_sync_in through 2 flip-flops each, then rising-edge detect; each detected edge sets pending flag line_pend or frame_pend.
REQ-016 SHALL capture hit_data into a 48-bit holding register and set hit_pend on hit_valid when hit_pend is 0, or when hit_pend is being cleared the same cycle.
REQ-017 SHALL discard a hit arriving while hit_pend is 1 and not cleared that cycle: the holding register is unchanged and drop_cnt increments.
REQ-018 SHALL discard an edge whose pending flag is already set and increment drop_cnt; drop_cnt saturates at 16'hFFFF.
REQ-019 SHALL increment drop_cnt by 1 per cycle in which any discard occurs.
REQ-020 SHALL implement FSM states IDLE, REQ_HIT, REQ_LINE, REQ_FRAME, GAP.
REQ-021 SHALL in IDLE with fifo_full = 0 transition to the highest-priority pending event: hit > line > frame; with fifo_full = 1 it SHALL remain in IDLE.
REQ-022 SHALL assert only the matching request output while in REQ_* (s1_wr_en, new_line or new_frame), registered, with s1_din driven from the holding register.
REQ-023 SHALL, on the matching done input sampled at 1 in REQ_*, clear that pending flag and go to GAP at the next edge; the request is therefore high exactly while in REQ_*.
REQ-024 SHALL spend exactly one cycle in GAP with all requests low, then return to IDLE, so back-to-back events are separated by at least one idle cycle.
REQ-025 SHALL increment line_index on accepted line done, wrapping 16'hFFFF to 0; accepted frame done SHALL clear line_index to 0.
REQ-026 SHALL count cycles in REQ_* with a 16-bit counter cleared on entry; when it reaches DONE_TIMEOUT without done, the FSM SHALL clear that pending flag, set ack_timeout_err, increment drop_cnt and go to GAP.
REQ-027 SHALL ignore done inputs not matching the current REQ_* state and all done inputs in IDLE and GAP.
REQ-028 SHALL hold fifo_full irrelevant once in REQ_*: a request already issued is not withdrawn.
REQ-029 SHALL, when line and frame edges are detected on the same cycle, set both pending flags; line is issued before frame.

Reset
REQ-030 SHALL on rst = 0 asynchronously force FSM to IDLE and set s1_wr_en, new_line and new_frame to 0, s1_din to 0, line_index to 0, drop_cnt to 0, ack_timeout_err to 0, all pending flags to 0 and synchronizers to 0.
REQ-031 SHALL, on reset mid-request, drop the pending event without counting it; ack_timeout_err is cleared only by reset.

Verification
REQ-032 Hit 48'h0000_1234_5678 strobe, s1_fifo_writing_done returned 1 cycle after s1_wr_en rises -> s1_wr_en high 2 cycles, s1_din = 48'h0000_1234_5678, 1 GAP cycle, drop_cnt = 0.
REQ-033 Hits on 3 consecutive cycles, done withheld 5 cycles -> first hit written, drop_cnt = 2.
REQ-034 Line and frame edges on the same cycle, no hit -> new_line then new_frame issued in order; line_index goes 1 and then 0.
REQ-035 Pending hit with fifo_full = 1 for 10 cycles -> no request asserted; request issued 1 cycle after fifo_full falls.
REQ-036 DONE_TIMEOUT = 4, new_line never acknowledged -> new_line high 4 cycles, then ack_timeout_err = 1, drop_cnt = 1, line_index unchanged.
REQ-037 rst = 0 asserted while s1_wr_en = 1 -> all outputs 0 without waiting for clk; after release, no request until a new event arrives.

Source files
------------

// File: rtl/tdc_event_sequencer.sv
// rtl/tdc_event_sequencer.sv - TDC hit / line / frame event sequencer toward the FIFO manager
//
// Purpose:
//   Collects TDC hits and scanner line/frame sync edges into single-entry
//   pending slots and issues them one at a time as write requests to the
//   FIFO manager, waiting for the matching done acknowledge (or a timeout)
//   and leaving one guard cycle between consecutive requests.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-low reset
//   hit_valid, hit_data   one-cycle hit strobe and 48-bit TDC word
//   line_sync_in          asynchronous line sync level
//   frame_sync_in         asynchronous frame sync level
//   fifo_full             downstream FIFO full; blocks starting a new request
//   s1_fifo_writing_done  acknowledge for s1_wr_en
//   new_line_FIFO_done    acknowledge for new_line
//   new_frame_FIFO_done   acknowledge for new_frame
//   s1_wr_en, s1_din      hit write request and hit word
//   new_line, new_frame   marker write requests
//   line_index            lines accepted since the last frame marker
//   drop_cnt              saturating count of discarded events
//   ack_timeout_err       sticky: some request was never acknowledged

module tdc_event_sequencer #(
    parameter int DONE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_valid,
    input  logic [47:0] hit_data,
    input  logic        line_sync_in,
    input  logic        frame_sync_in,
    input  logic        fifo_full,
    input  logic        s1_fifo_writing_done,
    input  logic        new_line_FIFO_done,
    input  logic        new_frame_FIFO_done,
    output logic        s1_wr_en,
    output logic [47:0] s1_din,
    output logic        new_line,
    output logic        new_frame,
    output logic [15:0] line_index,
    output logic        ack_timeout_err,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ_HIT   = 3'd1,
        REQ_LINE  = 3'd2,
        REQ_FRAME = 3'd3,
        GAP       = 3'd4
    } state_t;

    // The request counter starts at 0 on the first REQ cycle, so the last
    // allowed cycle is the one where it holds DONE_TIMEOUT-1.
    localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] req_cnt;

    // [0] and [1] form the two-stage synchronizer, [2] is the previous
    // synchronized value used for rising-edge detection.
    logic [2:0]  line_sync;
    logic [2:0]  frame_sync;
    logic        line_edge;
    logic        frame_edge;

    logic        hit_pend;
    logic        line_pend;
    logic        frame_pend;
    logic [47:0] hit_hold;

    logic        in_req;
    logic        done_match;
    logic        req_timeout;
    logic        req_end;
    logic        hit_clr;
    logic        line_clr;
    logic        frame_clr;
    logic        line_done;
    logic        frame_done;
    logic        hit_accept;
    logic        hit_drop;
    logic        line_drop;
    logic        frame_drop;
    logic        discard;

    // ------------------------------------------------------------------
    // Sync inputs: 2-FF synchronizer plus edge history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_sync  <= '0;
            frame_sync <= '0;
        end else begin
            line_sync  <= {line_sync[1:0], line_sync_in};
            frame_sync <= {frame_sync[1:0], frame_sync_in};
        end
    end

    assign line_edge  = line_sync[1]  & ~line_sync[2];
    assign frame_edge = frame_sync[1] & ~frame_sync[2];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    assign in_req = (state_q == REQ_HIT) || (state_q == REQ_LINE) || (state_q == REQ_FRAME);

    always_comb begin
        state_d     = state_q;
        done_match  = 1'b0;
        req_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full) begin
                    if (hit_pend) begin
                        state_d = REQ_HIT;
                    end else if (line_pend) begin
                        state_d = REQ_LINE;
                    end else if (frame_pend) begin
                        state_d = REQ_FRAME;
                    end
                end
            end
            REQ_HIT:   done_match = s1_fifo_writing_done;
            REQ_LINE:  done_match = new_line_FIFO_done;
            REQ_FRAME: done_match = new_frame_FIFO_done;
            GAP:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // A done arriving on the last allowed cycle still counts as success.
        if (in_req && !done_match && (req_cnt == TIMEOUT_LAST)) begin
            req_timeout = 1'b1;
        end
        if (in_req && (done_match || req_timeout)) begin
            state_d = GAP;
        end
    end

    assign req_end    = done_match || req_timeout;
    assign hit_clr    = (state_q == REQ_HIT)   && req_end;
    assign line_clr   = (state_q == REQ_LINE)  && req_end;
    assign frame_clr  = (state_q == REQ_FRAME) && req_end;
    assign line_done  = (state_q == REQ_LINE)  && done_match;
    assign frame_done = (state_q == REQ_FRAME) && done_match;

    // A hit may reuse the slot on the very cycle it is being released;
    // sync edges only see the flag value and are dropped while it is set.
    assign hit_accept = hit_valid && (!hit_pend || hit_clr);
    assign hit_drop   = hit_valid && !hit_accept;
    assign line_drop  = line_edge && line_pend;
    assign frame_drop = frame_edge && frame_pend;
    assign discard    = hit_drop || line_drop || frame_drop || req_timeout;

    // ------------------------------------------------------------------
    // State register and request-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (in_req && (state_d == state_q)) begin
                req_cnt <= req_cnt + 16'd1;
            end else begin
                req_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending slots
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_pend   <= 1'b0;
            hit_hold   <= '0;
            line_pend  <= 1'b0;
            frame_pend <= 1'b0;
        end else begin
            if (hit_accept) begin
                hit_pend <= 1'b1;
                hit_hold <= hit_data;
            end else if (hit_clr) begin
                hit_pend <= 1'b0;
            end

            if (line_clr) begin
                line_pend <= 1'b0;
            end else if (line_edge) begin
                line_pend <= 1'b1;
            end

            if (frame_clr) begin
                frame_pend <= 1'b0;
            end else if (frame_edge) begin
                frame_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_wr_en        <= 1'b0;
            new_line        <= 1'b0;
            new_frame       <= 1'b0;
            s1_din          <= '0;
            line_index      <= '0;
            ack_timeout_err <= 1'b0;
            drop_cnt        <= '0;
        end else begin
            s1_wr_en  <= (state_d == REQ_HIT);
            new_line  <= (state_d == REQ_LINE);
            new_frame <= (state_d == REQ_FRAME);

            // The holding register cannot change during REQ_HIT (new hits
            // are dropped), so loading on entry is enough.
            if ((state_d == REQ_HIT) && (state_q != REQ_HIT)) begin
                s1_din <= hit_hold;
            end

            if (line_done) begin
                line_index <= line_index + 16'd1;
            end else if (frame_done) begin
                line_index <= '0;
            end

            if (req_timeout) begin
                ack_timeout_err <= 1'b1;
            end

            if (discard && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_event_sequencer.sv
// tb/tb_tdc_event_sequencer.sv - self-checking bench for tdc_event_sequencer
module tb_tdc_event_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hit_valid;
    logic [47:0] hit_data;
    logic        line_sync_in;
    logic        frame_sync_in;
    logic        fifo_full;
    logic        s1_fifo_writing_done;
    logic        new_line_FIFO_done;
    logic        new_frame_FIFO_done;
    logic        s1_wr_en;
    logic [47:0] s1_din;
    logic        new_line;
    logic        new_frame;
    logic [15:0] line_index;
    logic        ack_timeout_err;
    logic [15:0] drop_cnt;

    logic m_wdone, m_ldone, m_fdone;
    logic r_wdone, r_ldone, r_fdone;
    logic auto_ack;
    int   ack_lat;
    int   ack_cnt;

    assign s1_fifo_writing_done = auto_ack ? r_wdone : m_wdone;
    assign new_line_FIFO_done   = auto_ack ? r_ldone : m_ldone;
    assign new_frame_FIFO_done  = auto_ack ? r_fdone : m_fdone;

    logic        to_line_sync, to_wdone, to_fdone;
    logic        to_wr_en, to_new_line, to_new_frame, to_err;
    logic [47:0] to_din;
    logic [15:0] to_idx, to_drop;

    int total = 0;
    int bad   = 0;

    tdc_event_sequencer dut (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_data(hit_data),
        .line_sync_in(line_sync_in), .frame_sync_in(frame_sync_in), .fifo_full(fifo_full),
        .s1_fifo_writing_done(s1_fifo_writing_done), .new_line_FIFO_done(new_line_FIFO_done),
        .new_frame_FIFO_done(new_frame_FIFO_done), .s1_wr_en(s1_wr_en), .s1_din(s1_din),
        .new_line(new_line), .new_frame(new_frame), .line_index(line_index),
        .ack_timeout_err(ack_timeout_err), .drop_cnt(drop_cnt)
    );

    tdc_event_sequencer #(.DONE_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .hit_valid(1'b0), .hit_data(48'd0),
        .line_sync_in(to_line_sync), .frame_sync_in(1'b0), .fifo_full(1'b0),
        .s1_fifo_writing_done(to_wdone), .new_line_FIFO_done(1'b0),
        .new_frame_FIFO_done(to_fdone), .s1_wr_en(to_wr_en), .s1_din(to_din),
        .new_line(to_new_line), .new_frame(to_new_frame), .line_index(to_idx),
        .ack_timeout_err(to_err), .drop_cnt(to_drop)
    );

    // Automatic acknowledge: done for the active request after ack_lat extra cycles.
    always @(negedge clk) begin
        if (auto_ack === 1'b1 && (s1_wr_en || new_line || new_frame)) begin
            if (ack_cnt >= ack_lat) begin
                r_wdone = s1_wr_en;
                r_ldone = new_line;
                r_fdone = new_frame;
                ack_cnt = 0;
            end else begin
                r_wdone = 1'b0;
                r_ldone = 1'b0;
                r_fdone = 1'b0;
                ack_cnt = ack_cnt + 1;
            end
        end else begin
            r_wdone = 1'b0;
            r_ldone = 1'b0;
            r_fdone = 1'b0;
            ack_cnt = 0;
        end
    end

    // Transaction monitor: one record per request, with its length, the
    // number of low cycles before it and line_index in the cycle after it.
    typedef struct {
        int          kind;
        logic [47:0] data;
        int          len;
        int          gap;
        logic [15:0] idx;
    } txn_t;

    txn_t mon_q[$];
    txn_t cur;
    bit   m_active = 1'b0;
    int   low_cnt  = 100;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            m_active = 1'b0;
            low_cnt  = 100;
        end else if (s1_wr_en || new_line || new_frame) begin
            if (!m_active) begin
                m_active = 1'b1;
                cur.kind = ({new_frame, new_line, s1_wr_en} == 3'b001) ? 0 :
                           ({new_frame, new_line, s1_wr_en} == 3'b010) ? 1 :
                           ({new_frame, new_line, s1_wr_en} == 3'b100) ? 2 : 9;
                cur.data = s1_din;
                cur.len  = 0;
                cur.gap  = low_cnt;
            end
            cur.len = cur.len + 1;
        end else begin
            if (m_active) begin
                cur.idx = line_index;
                mon_q.push_back(cur);
                m_active = 1'b0;
                low_cnt  = 0;
            end
            if (low_cnt < 100) low_cnt = low_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        hit_valid = 1'b0; hit_data = '0; line_sync_in = 1'b0; frame_sync_in = 1'b0;
        fifo_full = 1'b0; m_wdone = 1'b0; m_ldone = 1'b0; m_fdone = 1'b0;
        auto_ack = 1'b0; ack_lat = 0;
        to_line_sync = 1'b0; to_wdone = 1'b0; to_fdone = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic wait_txns(input int n, input string name);
        int i;
        i = 0;
        while (mon_q.size() < n && i < 400) begin
            tick(1);
            i++;
        end
        total++;
        if (mon_q.size() < n) begin
            bad++;
            $display("FAIL %s: transactions seen=%0d required=%0d", name, mon_q.size(), n);
        end
    endtask

    task automatic wait_wr_en(input string name);
        for (int i = 0; i < 20 && s1_wr_en !== 1'b1; i++) tick(1);
        total++;
        if (s1_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL %s: s1_wr_en=%b required=1", name, s1_wr_en);
        end
    endtask

    task automatic pulse_hit(input logic [47:0] d);
        hit_valid = 1'b1;
        hit_data  = d;
        tick(1);
        hit_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (s1_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", s1_wr_en); end
        total++; if ({new_line, new_frame} !== 2'b00) begin bad++; $display("FAIL reset_markers: got %b want 00", {new_line, new_frame}); end
        total++; if (s1_din !== 48'd0) begin bad++; $display("FAIL reset_din: got %h want 0", s1_din); end
        total++; if (line_index !== 16'd0) begin bad++; $display("FAIL reset_line_index: got %0d want 0", line_index); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        total++; if (ack_timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", ack_timeout_err); end
    endtask

    task automatic test_single_hit;
        int base;
        txn_t t;
        do_reset();
        base = mon_q.size();
        auto_ack = 1'b1; ack_lat = 1;
        pulse_hit(48'h0000_1234_5678);
        wait_txns(base + 1, "single_hit_seen");
        tick(3);
        if (mon_q.size() > base) begin
            t = mon_q[base];
            total++; if (t.kind !== 0) begin bad++; $display("FAIL single_hit_kind: got %0d want 0", t.kind); end
            total++; if (t.data !== 48'h0000_1234_5678) begin bad++; $display("FAIL single_hit_data: got %h want 000012345678", t.data); end
            total++; if (t.len !== 2) begin bad++; $display("FAIL single_hit_len: got %0d want 2", t.len); end
        end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL single_hit_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_back_to_back;
        int base;
        txn_t a, b;
        do_reset();
        base = mon_q.size();
        pulse_hit(48'hAAAA_0000_0001);
        wait_wr_en("b2b_first_req");
        m_wdone = 1'b1;
        hit_valid = 1'b1; hit_data = 48'h5555_0000_0002;
        tick(1);
        m_wdone = 1'b0; hit_valid = 1'b0;
        auto_ack = 1'b1; ack_lat = 0;
        wait_txns(base + 2, "b2b_seen");
        tick(3);
        if (mon_q.size() > base + 1) begin
            a = mon_q[base];
            b = mon_q[base + 1];
            total++; if (a.data !== 48'hAAAA_0000_0001 || a.len !== 1) begin bad++; $display("FAIL b2b_first: data=%h len=%0d want aaaa00000001 len 1", a.data, a.len); end
            total++; if (b.kind !== 0 || b.data !== 48'h5555_0000_0002) begin bad++; $display("FAIL b2b_second: kind=%0d data=%h want 0 555500000002", b.kind, b.data); end
            total++; if (b.gap !== 2) begin bad++; $display("FAIL b2b_gap: got %0d want 2", b.gap); end
        end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_drop_burst;
        int base;
        txn_t t;
        do_reset();
        base = mon_q.size();
        auto_ack = 1'b1; ack_lat = 5;
        hit_valid = 1'b1;
        hit_data = 48'h0000_0000_0A01; tick(1);
        hit_data = 48'h0000_0000_0A02; tick(1);
        hit_data = 48'h0000_0000_0A03; tick(1);
        hit_valid = 1'b0;
        wait_txns(base + 1, "burst_seen");
        tick(3);
        if (mon_q.size() > base) begin
            t = mon_q[base];
            total++; if (t.data !== 48'h0000_0000_0A01) begin bad++; $display("FAIL burst_data: got %h want 000000000a01", t.data); end
            total++; if (t.len !== 6) begin bad++; $display("FAIL burst_len: got %0d want 6", t.len); end
        end
        total++; if (mon_q.size() !== base + 1) begin bad++; $display("FAIL burst_count: got %0d want %0d", mon_q.size() - base, 1); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL burst_drop: got %0d want 2", drop_cnt); end
    endtask

    task automatic test_line_frame;
        int base;
        txn_t l, f;
        do_reset();
        base = mon_q.size();
        auto_ack = 1'b1; ack_lat = 1;
        line_sync_in = 1'b1; frame_sync_in = 1'b1;
        tick(4);
        line_sync_in = 1'b0; frame_sync_in = 1'b0;
        wait_txns(base + 2, "lf_seen");
        tick(3);
        if (mon_q.size() > base + 1) begin
            l = mon_q[base];
            f = mon_q[base + 1];
            total++; if (l.kind !== 1 || l.idx !== 16'd1) begin bad++; $display("FAIL lf_line: kind=%0d idx=%0d want 1 1", l.kind, l.idx); end
            total++; if (f.kind !== 2 || f.idx !== 16'd0) begin bad++; $display("FAIL lf_frame: kind=%0d idx=%0d want 2 0", f.kind, f.idx); end
            total++; if (f.gap !== 2) begin bad++; $display("FAIL lf_gap: got %0d want 2", f.gap); end
        end
    endtask

    task automatic test_fifo_full;
        int base;
        bit seen;
        txn_t t;
        do_reset();
        base = mon_q.size();
        fifo_full = 1'b1;
        pulse_hit(48'h0000_BEEF_0001);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (s1_wr_en || new_line || new_frame) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ff_blocked: request seen=%b want 0", seen); end
        fifo_full = 1'b0;
        total++; if (s1_wr_en !== 1'b0) begin bad++; $display("FAIL ff_not_early: wr_en=%b want 0", s1_wr_en); end
        tick(1);
        total++; if (s1_wr_en !== 1'b1) begin bad++; $display("FAIL ff_release: wr_en=%b want 1", s1_wr_en); end
        fifo_full = 1'b1;
        tick(3);
        total++; if (s1_wr_en !== 1'b1) begin bad++; $display("FAIL ff_no_withdraw: wr_en=%b want 1", s1_wr_en); end
        m_wdone = 1'b1;
        tick(1);
        m_wdone = 1'b0; fifo_full = 1'b0;
        wait_txns(base + 1, "ff_seen");
        if (mon_q.size() > base) begin
            t = mon_q[base];
            total++; if (t.len !== 4 || t.data !== 48'h0000_BEEF_0001) begin bad++; $display("FAIL ff_txn: len=%0d data=%h want 4 0000beef0001", t.len, t.data); end
        end
    endtask

    task automatic test_timeout;
        int cnt;
        do_reset();
        to_wdone = 1'b1; to_fdone = 1'b1;
        to_line_sync = 1'b1;
        for (int i = 0; i < 20 && to_new_line !== 1'b1; i++) tick(1);
        cnt = 0;
        while (to_new_line === 1'b1 && cnt < 20) begin
            cnt++;
            tick(1);
        end
        total++; if (cnt !== 4) begin bad++; $display("FAIL to_len: new_line cycles=%0d want 4", cnt); end
        total++; if (to_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", to_err); end
        total++; if (to_drop !== 16'd1) begin bad++; $display("FAIL to_drop: got %0d want 1", to_drop); end
        total++; if (to_idx !== 16'd0) begin bad++; $display("FAIL to_idx: got %0d want 0", to_idx); end
        to_line_sync = 1'b0; to_wdone = 1'b0; to_fdone = 1'b0;
        tick(6);
        total++; if (to_err !== 1'b1 || to_new_line !== 1'b0) begin bad++; $display("FAIL to_sticky: err=%b new_line=%b want 1 0", to_err, to_new_line); end
        total++; if (ack_timeout_err !== 1'b0) begin bad++; $display("FAIL main_err: got %b want 0", ack_timeout_err); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int base;
        do_reset();
        hit_valid = 1'b1;
        hit_data = 48'h0000_0000_C001; tick(1);
        hit_data = 48'h0000_0000_C002; tick(1);
        hit_valid = 1'b0;
        wait_wr_en("rm_req");
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL rm_pre_drop: got %0d want 1", drop_cnt); end
        #2;
        rst = 1'b0;
        #1;
        total++; if ({s1_wr_en, new_line, new_frame} !== 3'b000) begin bad++; $display("FAIL rm_async_req: got %b want 000", {s1_wr_en, new_line, new_frame}); end
        total++; if (s1_din !== 48'd0 || drop_cnt !== 16'd0) begin bad++; $display("FAIL rm_async_regs: din=%h drop=%0d want 0 0", s1_din, drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
        base = mon_q.size();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (s1_wr_en || new_line || new_frame) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_no_req: request seen=%b want 0", seen); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rm_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_random;
        txn_t exp_q[$];
        txn_t e, t;
        int base, kind, lat, ff, model_idx;
        logic [47:0] d;
        do_reset();
        base = mon_q.size();
        model_idx = 0;
        auto_ack = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            lat  = int'($urandom_range(0, 5));
            ff   = int'($urandom_range(0, 3));
            ack_lat = lat;
            if (ff != 0) fifo_full = 1'b1;
            e.len = lat + 1; e.gap = 0; e.data = '0; e.idx = '0;
            if (kind == 0) begin
                d = {16'($urandom), 32'($urandom)};
                e.kind = 0; e.data = d;
                exp_q.push_back(e);
                pulse_hit(d);
            end else begin
                if (kind == 1 || kind == 3) begin
                    model_idx = (model_idx + 1) % 65536;
                    e.kind = 1; e.idx = 16'(model_idx);
                    exp_q.push_back(e);
                    line_sync_in = 1'b1;
                end
                if (kind == 2 || kind == 3) begin
                    model_idx = 0;
                    e.kind = 2; e.idx = 16'd0;
                    exp_q.push_back(e);
                    frame_sync_in = 1'b1;
                end
            end
            tick(ff + 3);
            fifo_full = 1'b0; line_sync_in = 1'b0; frame_sync_in = 1'b0;
            wait_txns(base + exp_q.size(), "rand_seen");
            tick(3);
        end
        for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
            e = exp_q[i];
            t = mon_q[base + i];
            total++;
            if (t.kind !== e.kind || t.len !== e.len) begin
                bad++;
                $display("FAIL rand_txn%0d: kind=%0d len=%0d want %0d %0d", i, t.kind, t.len, e.kind, e.len);
            end
            total++;
            if ((e.kind == 0 && t.data !== e.data) || (e.kind != 0 && t.idx !== e.idx)) begin
                bad++;
                $display("FAIL rand_val%0d: data=%h idx=%0d want %h %0d", i, t.data, t.idx, e.data, e.idx);
            end
        end
        total++; if (drop_cnt !== 16'd0 || ack_timeout_err !== 1'b0) begin bad++; $display("FAIL rand_status: drop=%0d err=%b want 0 0", drop_cnt, ack_timeout_err); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_back_to_back();
        test_drop_burst();
        test_line_frame();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
